// File: rtl/mux2_bist_pkg.sv
// rtl/mux2_bist_pkg.sv - shared types, constants and golden model for the mux2 self-test engine
package mux2_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

    function automatic logic golden_z(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/mux2_bist_if.sv
// rtl/mux2_bist_if.sv - connection between the self-test engine and the mux under test
interface mux2_bist_if;
    logic sel;
    logic d0;
    logic d1;
    logic z;

    modport master (output sel, output d0, output d1, input z);
    modport slave  (input sel, input d0, input d1, output z);
endinterface

// File: rtl/mux2_bist_hold_timer.sv
// rtl/mux2_bist_hold_timer.sv - free-running hold counter with clear and terminal-count output
module mux2_bist_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Wraps on terminal count so consecutive vectors need no explicit reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = !clear && (cnt == LAST);

endmodule

// File: rtl/mux2_bist.sv
// rtl/mux2_bist.sv - walks all 8 mux2 input vectors, checks z and reports pass/fail
module mux2_bist
    import mux2_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    mux2_bist_if.master       mux,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [3:0]        err_count,
    output logic              fail_valid,
    output logic [VEC_W-1:0]  first_fail_idx
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_t            state, state_d;
    logic [VEC_W-1:0]  vec_idx, vec_d;
    logic [3:0]        err_d;
    logic              fv_d, busy_d, done_d, pass_d;
    logic [VEC_W-1:0]  ffi_d;
    logic              mismatch;
    logic              tick;

    mux2_bist_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state != RUN),
        .tc    (tick)
    );

    always_comb begin
        state_d  = state;
        vec_d    = vec_idx;
        err_d    = err_count;
        fv_d     = fail_valid;
        ffi_d    = first_fail_idx;
        busy_d   = busy;
        done_d   = done;
        pass_d   = pass;
        // Case inequality so an undriven or X mux output is reported as a failure.
        mismatch = (mux.z !== golden_z(vec_idx[2], vec_idx[1], vec_idx[0]));
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffi_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (tick) begin
                    if (mismatch) begin
                        err_d = err_count + 4'd1;
                        if (!fail_valid) begin
                            fv_d  = 1'b1;
                            ffi_d = vec_idx;
                        end
                    end
                    if (vec_idx == LAST_VEC) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 4'd0);
                    end else begin
                        vec_d = vec_idx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            vec_idx        <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mux.sel        <= 1'b0;
            mux.d0         <= 1'b0;
            mux.d1         <= 1'b0;
        end else begin
            state          <= state_d;
            vec_idx        <= vec_d;
            err_count      <= err_d;
            fail_valid     <= fv_d;
            first_fail_idx <= ffi_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            mux.sel        <= (state_d == RUN) ? vec_d[2] : 1'b0;
            mux.d0         <= (state_d == RUN) ? vec_d[1] : 1'b0;
            mux.d1         <= (state_d == RUN) ? vec_d[0] : 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_bist.sv
// tb/tb_mux2_bist.sv - self-checking bench for mux2_bist with a behavioural mux and fault injection
module tb_mux2_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start1;
    logic       busy4, done4, pass4, fv4;
    logic [3:0] err4;
    logic [2:0] ffi4;
    logic       busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] ffi1;

    int         mode;
    logic [7:0] mask;
    int         checks   = 0;
    int         failures = 0;

    mux2_bist_if m4();
    mux2_bist_if m1();

    always #5 clk = ~clk;

    // Mux under test: 0 good, 1 stuck-at-0, 2 inverted, 3 per-vector flip mask.
    function automatic logic mux_model(input int md, input logic [7:0] mk,
                                       input logic s, input logic a, input logic b);
        logic good;
        good = s ? b : a;
        case (md)
            1:       return 1'b0;
            2:       return ~good;
            3:       return good ^ mk[{s, a, b}];
            default: return good;
        endcase
    endfunction

    assign m4.z = mux_model(mode, mask, m4.sel, m4.d0, m4.d1);
    assign m1.z = m1.sel ? m1.d1 : m1.d0;

    mux2_bist #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start4), .mux(m4.master),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .fail_valid(fv4), .first_fail_idx(ffi4)
    );

    mux2_bist #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mux(m1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail_idx(ffi1)
    );

    task automatic run_h4(input string name);
        int         exp_err;
        int         exp_first;
        logic [2:0] vb;
        logic       obs;
        exp_err   = 0;
        exp_first = -1;
        for (int i = 0; i < 8; i++) begin
            vb  = i[2:0];
            obs = mux_model(mode, mask, vb[2], vb[1], vb[0]);
            if (obs != (vb[2] ? vb[0] : vb[1])) begin
                exp_err++;
                if (exp_first < 0) exp_first = i;
            end
        end
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            vb = 3'(j / 4);
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0 || {m4.sel, m4.d0, m4.d1} !== vb) begin
                failures++;
                $display("FAIL %s_run_cycle%0d: busy=%b done=%b vec=%b expected busy=1 done=0 vec=%b",
                         name, j, busy4, done4, {m4.sel, m4.d0, m4.d1}, vb);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || {m4.sel, m4.d0, m4.d1} !== 3'b000) begin
            failures++;
            $display("FAIL %s_done: done=%b busy=%b vec=%b expected done=1 busy=0 vec=000",
                     name, done4, busy4, {m4.sel, m4.d0, m4.d1});
        end
        checks++;
        if (err4 !== 4'(exp_err) || pass4 !== (exp_err == 0) || fv4 !== (exp_err != 0)) begin
            failures++;
            $display("FAIL %s_result: err=%0d pass=%b fail_valid=%b expected err=%0d pass=%b fail_valid=%b",
                     name, err4, pass4, fv4, exp_err, exp_err == 0, exp_err != 0);
        end
        if (exp_err != 0) begin
            checks++;
            if (ffi4 !== 3'(exp_first)) begin
                failures++;
                $display("FAIL %s_first_fail: got %0d expected %0d", name, ffi4, exp_first);
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        mask   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy4, done4, pass4, err4, fv4, ffi4, m4.sel, m4.d0, m4.d1} !== 16'h0) begin
            failures++;
            $display("FAIL reset_h4: outputs=%h expected 0",
                     {busy4, done4, pass4, err4, fv4, ffi4, m4.sel, m4.d0, m4.d1});
        end
        checks++;
        if ({busy1, done1, pass1, err1, fv1, ffi1, m1.sel, m1.d0, m1.d1} !== 16'h0) begin
            failures++;
            $display("FAIL reset_h1: outputs=%h expected 0",
                     {busy1, done1, pass1, err1, fv1, ffi1, m1.sel, m1.d0, m1.d1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        mode = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        checks++;
        if ({m4.sel, m4.d0, m4.d1} !== 3'b011 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL midrun_vec3: vec=%b busy=%b expected vec=011 busy=1",
                     {m4.sel, m4.d0, m4.d1}, busy4);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({busy4, done4, pass4, err4, fv4, ffi4, m4.sel, m4.d0, m4.d1} !== 16'h0) begin
            failures++;
            $display("FAIL midrun_async_reset: outputs=%h expected 0",
                     {busy4, done4, pass4, err4, fv4, ffi4, m4.sel, m4.d0, m4.d1});
        end
        @(negedge clk);
        rst = 1'b0;
        run_h4("after_reset");
    endtask

    task automatic test_restart();
        int waited;
        mode = 2;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            start4 = (j == 10);
            @(posedge clk); #1;
            start4 = 1'b0;
            checks++;
            if (done4 !== (j == 32)) begin
                failures++;
                $display("FAIL restart_ignore_cycle%0d: done=%b expected %b", j, done4, j == 32);
            end
        end
        checks++;
        if (err4 !== 4'd8 || ffi4 !== 3'd0 || pass4 !== 1'b0) begin
            failures++;
            $display("FAIL restart_invert_result: err=%0d first=%0d pass=%b expected err=8 first=0 pass=0",
                     err4, ffi4, pass4);
        end
        mode = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks++;
        if (done4 !== 1'b0 || err4 !== 4'd0 || fv4 !== 1'b0 || busy4 !== 1'b1 || pass4 !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear: done=%b err=%0d fv=%b busy=%b pass=%b expected 0 0 0 1 0",
                     done4, err4, fv4, busy4, pass4);
        end
        waited = 0;
        while (done4 !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (waited != 32 || pass4 !== 1'b1) begin
            failures++;
            $display("FAIL restart_rerun: cycles=%0d pass=%b expected cycles=32 pass=1", waited, pass4);
        end
    endtask

    task automatic test_hold1();
        logic [2:0] vb;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            vb = 3'(j);
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || {m1.sel, m1.d0, m1.d1} !== vb) begin
                failures++;
                $display("FAIL hold1_cycle%0d: busy=%b done=%b vec=%b expected 1 0 %b",
                         j, busy1, done1, {m1.sel, m1.d0, m1.d1}, vb);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || err1 !== 4'd0 || fv1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL hold1_done: done=%b pass=%b err=%0d fv=%b busy=%b expected 1 1 0 0 0",
                     done1, pass1, err1, fv1, busy1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            mode = 3;
            mask = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_h4($sformatf("random_mask%02h", mask));
        end
    endtask

    initial begin
        test_reset();
        mode = 0; run_h4("good");
        mode = 1; run_h4("stuck0");
        mode = 2; run_h4("invert");
        test_reset_mid_run();
        test_restart();
        test_hold1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
